i2c_addr_tx: RTL
================

// Module: i2c_addr_tx
// PURPOSE
//  Initiator-side address phase: serialises a 7-bit target address plus R/W bit,
//  one bit per bit_tick, then releases the line and waits for the target's
//  acknowledge. Bit order/ACK polarity match the team's address receiver.
//  Sits between the command sequencer and the SDA driver/bit-timing logic.
// PARAMETERS
//  MSB_FIRST    0    0: address bit 0 sent first (receiver-compatible); 1: bit 6 first
//  ACK_LEVEL    1    ack_in level that counts as ACK; other level = NACK
//  ACK_TIMEOUT  255  clk cycles to wait in WAIT_ACK for ack_valid (1..65535)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst        in   1  asynchronous reset, active high
//  start      in   1  pulse: begin address phase (accepted only in IDLE)
//  addr       in   7  target address, sampled on accepted start
//  rw         in   1  R/W bit, sampled on accepted start; sent as 8th bit
//  bit_tick   in   1  1-cycle bit-rate enable from bit-timing logic
//  ack_valid  in   1  1-cycle strobe: ack_in holds the sampled ACK-slot level
//  ack_in     in   1  line level in ACK slot
//  tx_out     out  1  serial data bit
//  tx_valid   out  1  1-cycle strobe, high in the cycle a new tx_out bit is driven
//  tx_oe      out  1  1 = drive tx_out on line; 0 = released (ACK slot/idle)
//  busy       out  1  high from accepted start until DONE exits
//  ack_ok     out  1  1-cycle pulse: target acknowledged
//  nack       out  1  1-cycle pulse: NACK or timeout
//  timeout    out  1  1-cycle pulse with nack when ACK_TIMEOUT expired
// BEHAVIOUR
//  Reset (async): state=IDLE; tx_out=1, tx_valid=0, tx_oe=0, busy=0, ack_ok=0,
//   nack=0, timeout=0; shift reg=0; bit counter=0; timeout counter=0.
//  FSM: IDLE -> SHIFT -> WAIT_ACK -> DONE -> IDLE.
//  IDLE: start=1 -> shreg<={rw,addr} (bit-reversed addr if MSB_FIRST),
//   cnt=0, busy=1, tx_oe=1, next SHIFT. Start outside IDLE ignored, no side effect.
//  SHIFT: on bit_tick: tx_out<=shreg[0], shreg>>=1, tx_valid=1 that cycle, cnt++.
//   Bits 0..6 address, bit 7 = rw. No tick -> hold tx_out, tx_valid=0.
//   The tick delivering bit 7 does not leave SHIFT; the next bit_tick (ACK slot
//   start) sets tx_oe=0, tx_out=1, tocnt=0, next WAIT_ACK. Start same cycle ignored.
//  WAIT_ACK: tx_oe=0. ack_valid=1 -> ack_in==ACK_LEVEL ? ack_ok=1 : nack=1; next DONE.
//   Else tocnt++; tocnt==ACK_TIMEOUT-1 without ack_valid -> nack=1, timeout=1, DONE.
//   ack_valid on the expiry cycle wins (ack evaluated, no timeout).
//   bit_tick ignored in WAIT_ACK.
//  DONE: one cycle; busy=0 on exit; outputs idle values; next IDLE.
//   Earliest new start accepted the cycle after DONE.
//  Latency: start -> first tx_valid = first bit_tick at least 1 clk after start.
//   Last tx_valid -> tx_oe=0 at next bit_tick. Result pulse 1 clk after ack_valid.
//  bit_tick coincident with start in IDLE not consumed as a data tick.
//  Counters: cnt 4 bits, tocnt 16 bits, saturating; no wrap.
//  Reset mid-operation: immediate return to reset values; no result pulse.
//  ack_ok/nack/timeout mutually exclusive except nack+timeout together.
// TESTING
//  T1 addr=7'h01,rw=1,MSB_FIRST=0, ticks every 4 clk -> tx_out 1,0,0,0,0,0,0,1;
//     ack_valid,ack_in=1 -> ack_ok one pulse, busy falls after DONE.
//  T2 addr=7'h5A,rw=0,MSB_FIRST=1 -> tx_out 1,0,1,1,0,1,0,0; ack_in=0 -> nack=1, timeout=0.
//  T3 ACK_TIMEOUT=16, no ack_valid -> nack=1 & timeout=1 exactly 16 clk after WAIT_ACK entry.
//  T4 start pulsed during SHIFT bit 3 with addr=7'h7F -> ignored; sequence unchanged.
//  T5 rst asserted async mid-SHIFT (bit 5) -> all outputs reset same cycle; no pulses;
//     new start after release sends full 8 bits from bit 0.
//  T6 start+bit_tick same cycle -> that tick unused; 8 later ticks yield 8 tx_valid pulses.

Source files
------------

// File: rtl/i2c_addr_tx.sv
// Initiator-side I2C address phase: shifts out 7 address bits plus R/W on bit_tick,
// releases the line for the ACK slot and reports ACK / NACK / timeout as 1-cycle pulses.
module i2c_addr_tx #(
    parameter int unsigned MSB_FIRST   = 0,
    parameter int unsigned ACK_LEVEL   = 1,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic       bit_tick,
    input  logic       ack_valid,
    input  logic       ack_in,
    output logic       tx_out,
    output logic       tx_valid,
    output logic       tx_oe,
    output logic       busy,
    output logic       ack_ok,
    output logic       nack,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic        ACK_LVL = (ACK_LEVEL != 0);

    state_t      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tocnt_q, tocnt_d;
    logic        tx_out_q, tx_out_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_oe_q, tx_oe_d;
    logic        busy_q, busy_d;
    logic        ack_ok_q, ack_ok_d;
    logic        nack_q, nack_d;
    logic        timeout_q, timeout_d;
    logic [6:0]  addr_ord;

    // The shifter always emits bit 0 first, so MSB-first order is a load-time reversal.
    always_comb begin
        addr_ord = addr;
        if (MSB_FIRST != 0) begin
            for (int unsigned i = 0; i < 7; i++) begin
                addr_ord[i] = addr[6 - i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            tocnt_q    <= '0;
            tx_out_q   <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_oe_q    <= 1'b0;
            busy_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            nack_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            tocnt_q    <= tocnt_d;
            tx_out_q   <= tx_out_d;
            tx_valid_q <= tx_valid_d;
            tx_oe_q    <= tx_oe_d;
            busy_q     <= busy_d;
            ack_ok_q   <= ack_ok_d;
            nack_q     <= nack_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_SHIFT;
            S_SHIFT:    if (bit_tick && cnt_q == 4'd8) state_d = S_WAIT_ACK;
            S_WAIT_ACK: if (ack_valid || tocnt_q == TO_LAST) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        tocnt_d    = tocnt_q;
        tx_out_d   = tx_out_q;
        tx_valid_d = 1'b0;
        tx_oe_d    = tx_oe_q;
        busy_d     = busy_q;
        ack_ok_d   = 1'b0;
        nack_d     = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                tx_oe_d  = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    shreg_d = {rw, addr_ord};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    tx_oe_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_tick) begin
                    if (cnt_q < 4'd8) begin
                        tx_out_d   = shreg_q[0];
                        shreg_d    = {1'b0, shreg_q[7:1]};
                        tx_valid_d = 1'b1;
                        cnt_d      = cnt_q + 4'd1;
                    end else begin
                        // Tick after bit 7 opens the ACK slot: release the line.
                        tx_oe_d  = 1'b0;
                        tx_out_d = 1'b1;
                        tocnt_d  = '0;
                    end
                end
            end
            S_WAIT_ACK: begin
                tx_oe_d = 1'b0;
                if (ack_valid) begin
                    if (ack_in == ACK_LVL) ack_ok_d = 1'b1;
                    else                   nack_d   = 1'b1;
                end else if (tocnt_q == TO_LAST) begin
                    nack_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (tocnt_q != '1) begin
                    tocnt_d = tocnt_q + 16'd1;
                end
            end
            S_DONE: begin
                tx_out_d = 1'b1;
                tx_oe_d  = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                tx_out_d = 1'b1;
                tx_oe_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign tx_out   = tx_out_q;
    assign tx_valid = tx_valid_q;
    assign tx_oe    = tx_oe_q;
    assign busy     = busy_q;
    assign ack_ok   = ack_ok_q;
    assign nack     = nack_q;
    assign timeout  = timeout_q;

endmodule
